// File: rtl/adc_avg_gain_mc.sv
// Multi-channel ADC averager: sums 2^LOG2_SAMPS samples per lane, scales by a latched gain,
// and writes one saturated fixed-point result per channel to the register bank.
module adc_avg_gain_mc #(
  parameter int NUM_CH     = 4,
  parameter int ADC_WIDTH  = 12,
  parameter int LOG2_SAMPS = 10,
  parameter int GAIN_WIDTH = 16,
  parameter int GAIN_SHIFT = 11,
  parameter int OUT_WIDTH  = 64,
  parameter int FRAC_WIDTH = 48,
  localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                        ADC_CLK,
  input  logic                        RST,
  input  logic [NUM_CH*ADC_WIDTH-1:0] ADC_DATA_IN,
  input  logic [GAIN_WIDTH-1:0]       GAIN_IN,
  input  logic                        START,
  input  logic                        CONT,
  output logic                        BUSY,
  output logic                        REG_RST,
  output logic                        REG_WRITE,
  output logic [CH_W-1:0]             CH_SEL,
  output logic [OUT_WIDTH-1:0]        DATA_OUT,
  output logic                        DONE
);

  localparam int ACC_W = ADC_WIDTH + LOG2_SAMPS;
  localparam int P_W   = ACC_W + GAIN_WIDTH;
  localparam int SH    = FRAC_WIDTH - LOG2_SAMPS - GAIN_SHIFT;
  localparam int R_W   = P_W + SH;
  localparam int EXT_W = (R_W > OUT_WIDTH) ? R_W : OUT_WIDTH + 1;

  typedef enum logic [1:0] {IDLE, CLEAR, ACCUM, OUT} state_t;

  state_t                state;
  logic [ACC_W-1:0]      acc [NUM_CH];
  logic [GAIN_WIDTH-1:0] gain;
  logic [LOG2_SAMPS-1:0] sample_cnt;
  logic [CH_W-1:0]       ch_idx;
  logic                  cont_pend;
  logic [P_W-1:0]        prod;
  logic [EXT_W-1:0]      scaled;
  logic                  sat;

  // One shared multiplier; the extra headroom above OUT_WIDTH detects saturation.
  always_comb begin
    prod   = P_W'(acc[ch_idx]) * P_W'(gain);
    scaled = EXT_W'(prod) << SH;
    sat    = |scaled[EXT_W-1:OUT_WIDTH];
  end

  // CONT is sampled on the last OUT edge; the automatic restart then passes through the
  // DONE cycle like a held START, so the next REG_RST lands right after DONE.
  always_ff @(posedge ADC_CLK or posedge RST) begin
    if (RST) begin
      state      <= IDLE;
      for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
      gain       <= '0;
      sample_cnt <= '0;
      ch_idx     <= '0;
      cont_pend  <= 1'b0;
      BUSY       <= 1'b0;
      REG_RST    <= 1'b0;
      REG_WRITE  <= 1'b0;
      DONE       <= 1'b0;
      CH_SEL     <= '0;
      DATA_OUT   <= '0;
    end else begin
      REG_RST   <= 1'b0;
      REG_WRITE <= 1'b0;
      DONE      <= 1'b0;
      case (state)
        IDLE: begin
          BUSY      <= START | cont_pend;
          cont_pend <= 1'b0;
          if (START | cont_pend) begin
            gain    <= GAIN_IN;
            REG_RST <= 1'b1;
            state   <= CLEAR;
          end
        end
        CLEAR: begin
          BUSY       <= 1'b1;
          for (int k = 0; k < NUM_CH; k++) acc[k] <= '0;
          sample_cnt <= '0;
          ch_idx     <= '0;
          state      <= ACCUM;
        end
        ACCUM: begin
          BUSY <= 1'b1;
          for (int k = 0; k < NUM_CH; k++)
            acc[k] <= acc[k] + ACC_W'(ADC_DATA_IN[k*ADC_WIDTH +: ADC_WIDTH]);
          sample_cnt <= sample_cnt + LOG2_SAMPS'(1);
          if (&sample_cnt) state <= OUT;
        end
        OUT: begin
          BUSY      <= 1'b1;
          REG_WRITE <= 1'b1;
          CH_SEL    <= ch_idx;
          DATA_OUT  <= sat ? '1 : scaled[OUT_WIDTH-1:0];
          ch_idx    <= ch_idx + CH_W'(1);
          if (ch_idx == CH_W'(NUM_CH - 1)) begin
            DONE      <= 1'b1;
            cont_pend <= CONT;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_avg_gain_mc.sv
// Randomised self-checking bench for adc_avg_gain_mc; expected results come from a
// mean*gain/2^GAIN_SHIFT reference model over the samples actually driven.
module tb_adc_avg_gain_mc;

  localparam int NUM_CH     = 4;
  localparam int ADC_WIDTH  = 12;
  localparam int LOG2_SAMPS = 10;
  localparam int N          = 1 << LOG2_SAMPS;
  localparam int GAIN_WIDTH = 16;
  localparam int GAIN_SHIFT = 11;
  localparam int OUT_WIDTH  = 64;
  localparam int FRAC_WIDTH = 48;

  logic                        clk;
  logic                        rst;
  logic [NUM_CH*ADC_WIDTH-1:0] adc_data;
  logic [GAIN_WIDTH-1:0]       gain_in;
  logic                        start;
  logic                        cont;
  logic                        busy;
  logic                        reg_rst;
  logic                        reg_write;
  logic [1:0]                  ch_sel;
  logic [OUT_WIDTH-1:0]        data_out;
  logic                        done;

  int          n_checks;
  int          n_pass;
  logic [63:0] last_data;

  adc_avg_gain_mc #(
    .NUM_CH(NUM_CH), .ADC_WIDTH(ADC_WIDTH), .LOG2_SAMPS(LOG2_SAMPS),
    .GAIN_WIDTH(GAIN_WIDTH), .GAIN_SHIFT(GAIN_SHIFT),
    .OUT_WIDTH(OUT_WIDTH), .FRAC_WIDTH(FRAC_WIDTH)
  ) dut (
    .ADC_CLK(clk), .RST(rst), .ADC_DATA_IN(adc_data), .GAIN_IN(gain_in),
    .START(start), .CONT(cont), .BUSY(busy), .REG_RST(reg_rst),
    .REG_WRITE(reg_write), .CH_SEL(ch_sel), .DATA_OUT(data_out), .DONE(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Result = mean * gain / 2^GAIN_SHIFT with FRAC_WIDTH fraction bits, clipped to all ones.
  function automatic logic [63:0] modelOut(input longint unsigned sum, input logic [15:0] g);
    logic [127:0] r;
    r = 128'(sum) * 128'(g);
    r = r << (FRAC_WIDTH - LOG2_SAMPS - GAIN_SHIFT);
    if (r >= (128'(1) << OUT_WIDTH)) return '1;
    return r[63:0];
  endfunction

  function automatic logic [11:0] genSample(input int mode, input int k, input int i);
    case (mode)
      0:       return 12'd2048;
      1:       return 12'(k * 1000 + 1);
      2:       return (k == 0) ? ((i % 2 == 1) ? 12'd4095 : 12'd0) : 12'($urandom_range(0, 4095));
      3:       return 12'd4095;
      default: return 12'($urandom_range(0, 4095));
    endcase
  endfunction

  // Runs one acquisition from its start cycle (c=0) through its DONE cycle.
  task automatic applyStimulus(input int mode, input logic [15:0] g, input logic start_val,
                               input logic cont_val, input logic [15:0] mid_gain, input string name);
    longint unsigned sums [NUM_CH];
    logic [63:0]     expv [NUM_CH];
    bit              busy_low;
    int              last_c;
    last_c   = N + 2 + NUM_CH;
    busy_low = 0;
    foreach (sums[k]) sums[k] = 0;
    foreach (expv[k]) expv[k] = '0;
    gain_in = g;
    start   = start_val;
    cont    = cont_val;
    for (int c = 0; c <= last_c; c++) begin
      if (c >= 1 && busy !== 1'b1) busy_low = 1;
      if (c == 1) begin
        checkOutput({name, "_reg_rst_c1"}, 64'(reg_rst), 64'd1);
        checkOutput({name, "_busy_c1"}, 64'(busy), 64'd1);
        start = 1'b0;
      end
      if (c == 2) checkOutput({name, "_reg_rst_c2"}, 64'(reg_rst), 64'd0);
      if (c == 5) start = 1'b1;
      if (c == 6) start = 1'b0;
      if (c == 100) gain_in = mid_gain;
      if (c == N + 2) begin
        checkOutput({name, "_no_early_write"}, 64'(reg_write), 64'd0);
        for (int k = 0; k < NUM_CH; k++) expv[k] = modelOut(sums[k], g);
      end
      if (c >= N + 3) begin
        int k;
        k = c - N - 3;
        checkOutput($sformatf("%s_wr%0d", name, k), 64'(reg_write), 64'd1);
        checkOutput($sformatf("%s_sel%0d", name, k), 64'(ch_sel), 64'(k));
        checkOutput($sformatf("%s_data%0d", name, k), data_out, expv[k]);
        checkOutput($sformatf("%s_done%0d", name, k), 64'(done), 64'(k == NUM_CH - 1));
      end
      for (int k = 0; k < NUM_CH; k++) begin
        logic [11:0] v;
        if (c >= 2 && c <= N + 1) begin
          v = genSample(mode, k, c - 2);
          sums[k] += longint'(v);
        end else begin
          v = 12'($urandom_range(0, 4095));
        end
        adc_data[k*ADC_WIDTH +: ADC_WIDTH] = v;
      end
      if (c < last_c) stepCycle();
    end
    checkOutput({name, "_busy_held"}, 64'(busy_low), 64'd0);
    last_data = expv[NUM_CH-1];
  endtask

  task automatic finishIdle(input string name);
    start = 1'b0;
    stepCycle();
    checkOutput({name, "_idle_busy"}, 64'(busy), 64'd0);
    checkOutput({name, "_idle_write"}, 64'(reg_write), 64'd0);
    checkOutput({name, "_idle_done"}, 64'(done), 64'd0);
    checkOutput({name, "_hold_sel"}, 64'(ch_sel), 64'(NUM_CH - 1));
    checkOutput({name, "_hold_data"}, data_out, last_data);
    stepCycle();
    checkOutput({name, "_stay_idle"}, 64'(reg_rst), 64'd0);
  endtask

  initial begin
    bit seen;
    n_checks  = 0;
    n_pass    = 0;
    last_data = '0;
    rst       = 1'b1;
    adc_data  = '0;
    gain_in   = '0;
    start     = 1'b0;
    cont      = 1'b0;
    #12;
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_reg_rst", 64'(reg_rst), 64'd0);
    checkOutput("rst_write", 64'(reg_write), 64'd0);
    checkOutput("rst_done", 64'(done), 64'd0);
    checkOutput("rst_sel", 64'(ch_sel), 64'd0);
    checkOutput("rst_data", data_out, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    stepCycle();
    stepCycle();

    $display("[TB] constant 2048, gain 20");
    applyStimulus(0, 16'd20, 1'b1, 1'b0, 16'd20, "const");
    checkOutput("const_literal", last_data, 64'h0014_0000_0000_0000);
    finishIdle("const");

    $display("[TB] per-channel ramp, gain 2048");
    applyStimulus(1, 16'd2048, 1'b1, 1'b0, 16'd2048, "ramp");
    finishIdle("ramp");

    $display("[TB] alternating 0/4095 on channel 0");
    applyStimulus(2, 16'd2048, 1'b1, 1'b0, 16'd2048, "alt");
    finishIdle("alt");

    $display("[TB] full scale with maximum gain");
    applyStimulus(3, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, "sat");
    finishIdle("sat");

    $display("[TB] continuous mode with mid-run gain change");
    begin
      logic [15:0] g1, g2;
      g1 = 16'($urandom_range(1, 65535));
      g2 = 16'($urandom_range(1, 65535));
      applyStimulus(4, g1, 1'b1, 1'b1, g2, "cont1");
      applyStimulus(4, g2, 1'b0, 1'b0, g2, "cont2");
      finishIdle("cont2");
    end

    $display("[TB] asynchronous reset mid-accumulation");
    gain_in = 16'($urandom_range(0, 65535));
    start   = 1'b1;
    stepCycle();
    start = 1'b0;
    repeat (300) begin
      adc_data = {4{12'($urandom_range(0, 4095))}};
      stepCycle();
    end
    #3 rst = 1'b1;
    #1;
    checkOutput("abort_busy", 64'(busy), 64'd0);
    checkOutput("abort_reg_rst", 64'(reg_rst), 64'd0);
    checkOutput("abort_write", 64'(reg_write), 64'd0);
    checkOutput("abort_done", 64'(done), 64'd0);
    checkOutput("abort_sel", 64'(ch_sel), 64'd0);
    checkOutput("abort_data", data_out, 64'd0);
    @(negedge clk);
    stepCycle();
    rst  = 1'b0;
    seen = 0;
    repeat (N + 20) begin
      adc_data = {4{12'($urandom_range(0, 4095))}};
      stepCycle();
      if (reg_write === 1'b1 || done === 1'b1 || busy === 1'b1) seen = 1;
    end
    checkOutput("abort_silent", 64'(seen), 64'd0);
    applyStimulus(4, 16'($urandom_range(0, 65535)), 1'b1, 1'b0,
                  16'($urandom_range(0, 65535)), "post_rst");
    finishIdle("post_rst");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
